apu_frame_sequencer: RTL
========================

APU_FRAME_SEQUENCER -- requirements
Module: apu_frame_sequencer

Interface
REQ-001 SHALL have parameter CW, default 16: width of the frame step counter.
REQ-002 SHALL have parameters STEP1..STEP5, defaults 7457, 14913, 22371, 29829, 37281: frame event positions in apu_ce counts.
REQ-003 SHALL have port clk  input  1  single system clock; all state is on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port apu_ce  input  1  one-cycle APU-rate clock enable; the counter advances only on cycles where it is high.
REQ-006 SHALL have port cfg_we  input  1  one-cycle configuration write strobe.
REQ-007 SHALL have port cfg_mode  input  1  sequence mode captured on cfg_we: 0 = 4-step, 1 = 5-step.
REQ-008 SHALL have port cfg_irq_inhibit  input  1  IRQ inhibit captured on cfg_we.
REQ-009 SHALL have port irq_ack  input  1  one-cycle frame IRQ clear.
REQ-010 SHALL have port quarter_tick  output  1  one-clk pulse that clocks envelopes and the linear counter.
REQ-011 SHALL have port half_tick  output  1  one-clk pulse that clocks length counters and sweeps.
REQ-012 SHALL have port irq  output  1  frame IRQ, level, sticky.
REQ-013 SHALL have port mode  output  1  currently active sequence mode.

Function
REQ-014 SHALL hold registered cnt (CW bits), mode, and inhibit state.
REQ-015 SHALL register all outputs, with no combinational path from any input to any output.
REQ-016 On an apu_ce cycle without cfg_we, SHALL evaluate the current cnt against STEPk and update cnt in the same edge.
REQ-017 SHALL assert each tick exactly one clk cycle, in the cycle after the evaluating edge.
REQ-018 4-step mode, at cnt==STEP1: quarter.
REQ-019 4-step mode, at cnt==STEP2: quarter and half.
REQ-020 4-step mode, at cnt==STEP3: quarter.
REQ-021 4-step mode, at cnt==STEP4: quarter and half; set irq if inhibit=0; cnt <- 0.
REQ-022 5-step mode, at cnt==STEP1: quarter.
REQ-023 5-step mode, at cnt==STEP2: quarter and half.
REQ-024 5-step mode, at cnt==STEP3: quarter.
REQ-025 5-step mode, at cnt==STEP4: no tick.
REQ-026 5-step mode, at cnt==STEP5: quarter and half; cnt <- 0; irq never set.
REQ-027 At all other cnt values, SHALL apply cnt <- cnt+1, modulo 2^CW.
REQ-028 Frame period SHALL be STEP4+1 apu_ce counts in 4-step mode and STEP5+1 apu_ce counts in 5-step mode.
REQ-029 SHALL NOT change any state on cycles with apu_ce=0, except for cfg_we and irq_ack effects.
REQ-030 On cfg_we, SHALL latch mode and inhibit and set cnt <- 0.
REQ-031 On cfg_we with cfg_irq_inhibit=1, SHALL clear irq.
REQ-032 On cfg_we with cfg_mode=1, SHALL pulse quarter_tick and half_tick in the next cycle.
REQ-033 cfg_we coinciding with apu_ce: cfg_we SHALL win; that apu_ce is consumed; no step evaluation.
REQ-034 irq_ack SHALL clear irq in the next cycle.
REQ-035 irq_ack coinciding with an irq set event: set SHALL win and irq stays 1.
REQ-036 Back-to-back cfg_we SHALL each restart the sequence; the last write defines mode.
REQ-037 STEP1<STEP2<STEP3<STEP4<STEP5<2^CW is a parameter precondition; behaviour outside it is undefined.

Reset
REQ-038 rst high SHALL immediately force cnt=0, mode=0, inhibit=0, quarter_tick=0, half_tick=0, and irq=0.
REQ-039 Reset asserted mid-frame SHALL abandon the sequence with no tick emitted.
REQ-040 After rst deasserts, the first apu_ce SHALL evaluate cnt=0.
REQ-041 After reset, the block SHALL operate in 4-step mode with IRQ enabled.

Verification (STEP1..5 = 3, 6, 9, 12, 15; CW=4; apu_ce every clk)
REQ-042 Reset, then 13 apu_ce -> quarter at cnt 3, 6, 9, 12; half at cnt 6, 12; irq=1 after cnt 12; cnt back to 0.
REQ-043 cfg_we mode=1 inhibit=0, then 16 apu_ce -> immediate quarter+half; then quarter at 3, 6, 9, 15; half at 6, 15; no tick at 12; irq stays 0.
REQ-044 irq=1, then irq_ack on the same cycle as the next STEP4 set -> irq remains 1; a later lone irq_ack -> irq=0 next cycle.
REQ-045 irq=1, then cfg_we inhibit=1 -> irq=0; 26 further apu_ce in 4-step mode -> irq never asserts.
REQ-046 cfg_we and apu_ce on the same cycle at cnt=5 -> cnt=0, no tick from cnt 5; next tick is quarter at cnt 3.
REQ-047 rst pulsed at cnt=8 -> all outputs 0 immediately, mode=0; sequence restarts from cnt 0.

Source files
------------

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: divides the APU-rate enable into quarter/half frame ticks
// and raises the sticky frame IRQ in 4-step mode.
module apu_frame_sequencer #(
    parameter int unsigned CW    = 16,
    parameter int unsigned STEP1 = 7457,
    parameter int unsigned STEP2 = 14913,
    parameter int unsigned STEP3 = 22371,
    parameter int unsigned STEP4 = 29829,
    parameter int unsigned STEP5 = 37281
) (
    input  logic clk,
    input  logic rst,
    input  logic apu_ce,
    input  logic cfg_we,
    input  logic cfg_mode,
    input  logic cfg_irq_inhibit,
    input  logic irq_ack,
    output logic quarter_tick,
    output logic half_tick,
    output logic irq,
    output logic mode
);

    localparam logic [CW-1:0] L_STEP1 = CW'(STEP1);
    localparam logic [CW-1:0] L_STEP2 = CW'(STEP2);
    localparam logic [CW-1:0] L_STEP3 = CW'(STEP3);
    localparam logic [CW-1:0] L_STEP4 = CW'(STEP4);
    localparam logic [CW-1:0] L_STEP5 = CW'(STEP5);

    logic [CW-1:0] r_cnt;
    logic          r_mode;
    logic          r_inhibit;
    logic          r_quarter;
    logic          r_half;
    logic          r_irq;

    logic [CW-1:0] w_cnt_next;
    logic          w_mode_next;
    logic          w_inhibit_next;
    logic          w_quarter_next;
    logic          w_half_next;
    logic          w_irq_next;

    always_comb begin
        w_cnt_next     = r_cnt;
        w_mode_next    = r_mode;
        w_inhibit_next = r_inhibit;
        w_quarter_next = 1'b0;
        w_half_next    = 1'b0;
        w_irq_next     = r_irq;

        if (irq_ack) begin
            w_irq_next = 1'b0;
        end

        // A config write restarts the frame and swallows any coincident apu_ce.
        if (cfg_we) begin
            w_mode_next    = cfg_mode;
            w_inhibit_next = cfg_irq_inhibit;
            w_cnt_next     = '0;
            if (cfg_irq_inhibit) begin
                w_irq_next = 1'b0;
            end
            if (cfg_mode) begin
                w_quarter_next = 1'b1;
                w_half_next    = 1'b1;
            end
        end else if (apu_ce) begin
            w_cnt_next = r_cnt + CW'(1);
            if (r_cnt == L_STEP1 || r_cnt == L_STEP3) begin
                w_quarter_next = 1'b1;
            end else if (r_cnt == L_STEP2) begin
                w_quarter_next = 1'b1;
                w_half_next    = 1'b1;
            end else if (!r_mode && r_cnt == L_STEP4) begin
                w_quarter_next = 1'b1;
                w_half_next    = 1'b1;
                w_cnt_next     = '0;
                if (!r_inhibit) begin
                    w_irq_next = 1'b1;
                end
            end else if (r_mode && r_cnt == L_STEP5) begin
                w_quarter_next = 1'b1;
                w_half_next    = 1'b1;
                w_cnt_next     = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_mode    <= 1'b0;
            r_inhibit <= 1'b0;
            r_quarter <= 1'b0;
            r_half    <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_mode    <= w_mode_next;
            r_inhibit <= w_inhibit_next;
            r_quarter <= w_quarter_next;
            r_half    <= w_half_next;
            r_irq     <= w_irq_next;
        end
    end

    assign quarter_tick = r_quarter;
    assign half_tick    = r_half;
    assign irq          = r_irq;
    assign mode         = r_mode;

endmodule
